// File: rtl/topk_uart_streamer_if.sv
// topk_uart_streamer_if
//   Bundles the start/size request, the FIFO read port and the UART/status
//   outputs of topk_uart_streamer.
//   master : host side (drives send/k and the FIFO read data, observes line/status)
//   slave  : streamer side
//   send_in       start pulse            k_in          word count of the frame
//   fifo_data_in  FIFO read data         fifo_valid_in read data valid (1 cycle after deq)
//   fifo_empty_in FIFO empty flag        fifo_deq_out  one-cycle pop request
//   uart_txd_out  8N1 serial line        busy_out      frame in progress
//   done_out      end-of-frame pulse
interface topk_uart_streamer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  send_in;
  logic [15:0]           k_in;
  logic [DATA_WIDTH-1:0] fifo_data_in;
  logic                  fifo_valid_in;
  logic                  fifo_empty_in;
  logic                  fifo_deq_out;
  logic                  uart_txd_out;
  logic                  busy_out;
  logic                  done_out;

  modport master (
    output send_in, k_in, fifo_data_in, fifo_valid_in, fifo_empty_in,
    input  fifo_deq_out, uart_txd_out, busy_out, done_out
  );

  modport slave (
    input  send_in, k_in, fifo_data_in, fifo_valid_in, fifo_empty_in,
    output fifo_deq_out, uart_txd_out, busy_out, done_out
  );
endinterface

// File: rtl/topk_uart_streamer.sv
// topk_uart_streamer
//   Pops K top-k result words from the result FIFO and sends them to the host
//   as one 8N1 UART frame: A5, K[7:0], K[15:8], K words LSB byte first, then
//   an XOR checksum over every byte except the A5 sync byte.
//   clk_in : system clock, rising edge
//   rst_in : asynchronous active-high reset; abandons any frame in flight
//   stream : slave modport of topk_uart_streamer_if (request, FIFO port, line, status)
module topk_uart_streamer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_WIDTH   = 32
) (
  input logic                 clk_in,
  input logic                 rst_in,
  topk_uart_streamer_if.slave stream
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [7:0]        SYNC     = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_POP, S_WAIT, S_WORD, S_CSUM, S_DONE
  } state_t;

  state_t                state;
  logic [15:0]           k_lat;
  logic [15:0]           words;     // words still to be sent, including the current one
  logic [7:0]            csum;
  logic [DATA_WIDTH-1:0] word;
  logic [1:0]            hdr_idx;   // header byte currently on the line
  logic [1:0]            byte_idx;  // next word byte to load; wraps to 0 after byte 3

  // byte engine
  logic [8:0]            shift;     // remaining data bits then stop bit
  logic [3:0]            bit_cnt;   // 0 = start, 1..8 = data, 9 = stop
  logic [CNT_W-1:0]      clk_cnt;
  logic                  tx_busy;

  logic                  txd, busy, done, deq;

  logic                  bit_last, byte_end, pop_go;
  logic                  ld, ld_acc;
  logic [7:0]            ld_byte;
  logic [DATA_WIDTH-1:0] word_sh;

  assign bit_last = (clk_cnt == CNT_LAST);
  assign byte_end = tx_busy && bit_last && (bit_cnt == 4'd9);
  assign pop_go   = !stream.fifo_empty_in;
  assign word_sh  = word >> {byte_idx, 3'b000};

  // Which byte (if any) starts on this edge. Loading on the same edge the
  // previous stop bit ends keeps consecutive bytes gapless. ld_acc marks
  // bytes folded into the checksum (not the sync byte, not the checksum).
  always_comb begin
    ld      = 1'b0;
    ld_acc  = 1'b0;
    ld_byte = 8'h00;
    case (state)
      S_IDLE: if (stream.send_in) begin
        ld      = 1'b1;
        ld_byte = SYNC;
      end
      S_HDR: if (byte_end) begin
        if (hdr_idx == 2'd0) begin
          ld = 1'b1; ld_acc = 1'b1; ld_byte = k_lat[7:0];
        end else if (hdr_idx == 2'd1) begin
          ld = 1'b1; ld_acc = 1'b1; ld_byte = k_lat[15:8];
        end else if (k_lat == 16'd0) begin
          ld = 1'b1; ld_byte = csum;
        end
      end
      // first word byte goes straight from the FIFO data so the gap stays at
      // the deq cycle plus the valid cycle
      S_WAIT: if (stream.fifo_valid_in) begin
        ld = 1'b1; ld_acc = 1'b1; ld_byte = stream.fifo_data_in[7:0];
      end
      S_WORD: if (byte_end) begin
        if (byte_idx != 2'd0) begin
          ld = 1'b1; ld_acc = 1'b1; ld_byte = word_sh[7:0];
        end else if (words == 16'd1) begin
          ld = 1'b1; ld_byte = csum;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= S_IDLE;
      k_lat    <= '0;
      words    <= '0;
      csum     <= '0;
      word     <= '0;
      hdr_idx  <= '0;
      byte_idx <= '0;
      shift    <= '1;
      bit_cnt  <= '0;
      clk_cnt  <= '0;
      tx_busy  <= 1'b0;
      txd      <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      deq      <= 1'b0;
    end else begin
      deq  <= 1'b0;
      done <= 1'b0;

      // byte engine: start bit on load, then shift out data and stop
      if (ld) begin
        txd     <= 1'b0;
        shift   <= {1'b1, ld_byte};
        bit_cnt <= '0;
        clk_cnt <= '0;
        tx_busy <= 1'b1;
        if (ld_acc) csum <= csum ^ ld_byte;
      end else if (byte_end) begin
        txd     <= 1'b1;
        tx_busy <= 1'b0;
      end else if (tx_busy) begin
        if (bit_last) begin
          clk_cnt <= '0;
          bit_cnt <= bit_cnt + 4'd1;
          txd     <= shift[0];
          shift   <= {1'b1, shift[8:1]};
        end else begin
          clk_cnt <= clk_cnt + 1'b1;
        end
      end

      case (state)
        S_IDLE: if (stream.send_in) begin
          k_lat   <= stream.k_in;
          words   <= stream.k_in;
          csum    <= '0;
          hdr_idx <= '0;
          busy    <= 1'b1;
          state   <= S_HDR;
        end
        S_HDR: if (byte_end) begin
          if (hdr_idx != 2'd2) begin
            hdr_idx <= hdr_idx + 2'd1;
          end else if (k_lat == 16'd0) begin
            state <= S_CSUM;
          end else if (pop_go) begin
            deq   <= 1'b1;
            state <= S_WAIT;
          end else begin
            state <= S_POP;
          end
        end
        S_POP: if (pop_go) begin
          deq   <= 1'b1;
          state <= S_WAIT;
        end
        S_WAIT: if (stream.fifo_valid_in) begin
          word     <= stream.fifo_data_in;
          byte_idx <= 2'd1;
          state    <= S_WORD;
        end
        S_WORD: if (byte_end) begin
          if (byte_idx != 2'd0) begin
            byte_idx <= byte_idx + 2'd1;
          end else begin
            words <= words - 16'd1;
            if (words == 16'd1) begin
              state <= S_CSUM;
            end else if (pop_go) begin
              deq   <= 1'b1;
              state <= S_WAIT;
            end else begin
              state <= S_POP;
            end
          end
        end
        S_CSUM: if (byte_end) begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_DONE;
        end
        // one-cycle tail so a send_in alongside done_out is not taken
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign stream.uart_txd_out = txd;
  assign stream.busy_out     = busy;
  assign stream.done_out     = done;
  assign stream.fifo_deq_out = deq;

endmodule

// File: doc/topk_uart_streamer.md
Name: topk_uart_streamer

Overview:
Drains top-k result words from the result FIFO and streams them to the host as one framed packet over an 8N1 UART transmit line. It is the reader/transmit end of the result path: the search engine enqueues top-k words into the FIFO, and this block pops and serializes them. It replaces register polling through the debug bridge for bulk result readout. Frame layout is 0xA5, then k[7:0], then k[15:8], then k words of 4 bytes each (LSB first), then a checksum byte.

Parameters:
CLKS_PER_BIT, 868, clk_in cycles per UART bit (100 MHz / 115200); legal range is 2 or more.
DATA_WIDTH, 32, width of a FIFO result word; fixed at 32, and the block always sends 4 bytes per word.

Ports:
clk_in  input  1  system clock; all logic on the rising edge.
rst_in  input  1  reset; asynchronous, active-high.
send_in  input  1  one-cycle start pulse; sampled only in IDLE.
k_in  input  16  number of words to send; latched on an accepted send_in.
fifo_data_in  input  32  FIFO read data; valid while fifo_valid_in is high.
fifo_valid_in  input  1  FIFO read-data valid; arrives 1 cycle after fifo_deq_out.
fifo_empty_in  input  1  FIFO empty flag.
fifo_deq_out  output  1  one-cycle pop request.
uart_txd_out  output  1  serial line; idles high.
busy_out  output  1  high while a frame is in progress.
done_out  output  1  one-cycle pulse at end of frame.

Behaviour:
- Reset (asynchronous, any cycle including mid-byte):
  - uart_txd_out=1, busy_out=0, done_out=0, fifo_deq_out=0.
  - State goes to IDLE; bit counter, byte counter, word counter and checksum all clear.
  - A partially sent frame is abandoned, not resumed.
- Byte engine:
  - Sends start bit (0), 8 data bits LSB first, then stop bit (1).
  - Each bit is held exactly CLKS_PER_BIT cycles, so one byte is 10*CLKS_PER_BIT cycles.
  - When the next byte is ready, its start bit begins the cycle after the previous stop bit ends (no gap).
- States: IDLE, HDR, POP, WAIT, WORD, CSUM, DONE.
  - IDLE:
    - send_in=1 latches K=k_in and clears the checksum; the next state is HDR.
    - busy_out rises and the start bit of 0xA5 drives the line on the cycle after send_in is sampled.
    - send_in at any other time is ignored.
  - HDR:
    - Sends 0xA5, then K[7:0], then K[15:8].
    - If K=0, go to CSUM; otherwise go to POP.
  - POP:
    - Waits with the line idle-high while fifo_empty_in=1.
    - When fifo_empty_in=0, asserts fifo_deq_out for exactly 1 cycle, then goes to WAIT.
  - WAIT:
    - Latches fifo_data_in when fifo_valid_in=1, then goes to WORD the next cycle.
    - Waits indefinitely otherwise.
    - With no stall, exactly 2 idle-high cycles separate bytes around a fetch: the deq cycle and the valid cycle.
  - WORD:
    - Sends bytes [7:0], [15:8], [23:16], [31:24].
    - Then decrements the remaining-word count.
    - Goes to POP if the count is non-zero, otherwise to CSUM.
  - CSUM: sends the checksum byte.
  - DONE:
    - On the cycle after the checksum stop bit completes, done_out=1 for 1 cycle and busy_out=0 in that same cycle.
    - Returns to IDLE; a send_in in that cycle is ignored.
- Checksum: XOR of every transmitted byte except the 0xA5 sync byte, covering both k bytes and all payload bytes.
- FIFO handling:
  - Exactly K pops per frame; never pops when fifo_empty_in=1.
  - No pops occur in IDLE, HDR or CSUM.
- Frame length with no stalls: (4+4K)*10*CLKS_PER_BIT + 2K cycles, counted from the first start bit to the last stop bit end.
- K=65535 is legal; the word counter is 16 bits wide and has no wrap.

Test Plan:
1. CLKS_PER_BIT=4; FIFO holds 0x11223344 and 0xDEADBEEF; send_in with k_in=2.
   - Line carries A5 02 00 44 33 22 11 EF BE AD DE 64.
   - Exactly 2 deq pulses; done_out pulses once; busy_out is high for the full frame.
2. k_in=0.
   - Line carries A5 00 00 00; no fifo_deq_out; done_out pulses after 4 bytes (160 cycles at CPB=4).
3. k_in=1 with the FIFO empty for 50 cycles after the header.
   - Line idle-high during the stall; a single deq occurs after empty falls.
   - Line then carries bytes of the pushed word plus the correct checksum.
4. Assert rst_in asynchronously mid-bit of the second payload byte.
   - uart_txd_out=1 and busy_out=0 immediately.
   - A later send_in with k_in=1 produces a complete, correct fresh frame.
5. Pulse send_in again while busy, and also in the done_out cycle.
   - Both ignored; only one frame is emitted; K is unchanged.
6. CLKS_PER_BIT=868.
   - Each bit measures exactly 868 cycles.
   - Back-to-back header bytes show no idle gap between stop bit and start bit.
